// File: rtl/sad_ctrl_pkg.sv
// Shared state encoding and bank/loader codes for the SAD search controller.
package sad_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WIN,
        LOAD_FRM,
        WAIT_SAD,
        COMPARE,
        ADVANCE,
        DONE
    } state_t;

    localparam logic [1:0] REGWR_NONE   = 2'b00;
    localparam logic [1:0] REGWR_WINDOW = 2'b01;
    localparam logic [1:0] REGWR_FRAME  = 2'b11;

    localparam logic LOADSEL_WIN = 1'b0;
    localparam logic LOADSEL_FRM = 1'b1;

endpackage

// File: rtl/sad_pos_counter.sv
// Raster-order block position counter: col runs 0..FRAME_W-WIN, then row steps.
module sad_pos_counter #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN     = 4,
    parameter int COORD_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Clear,
    input  logic               Step,
    output logic [COORD_W-1:0] Row,
    output logic [COORD_W-1:0] Col,
    output logic [COORD_W-1:0] NextRow,
    output logic [COORD_W-1:0] NextCol,
    output logic               LastPos
);

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(FRAME_W - WIN);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(FRAME_H - WIN);

    assign LastPos = (Row == LAST_ROW) && (Col == LAST_COL);

    always_comb begin
        NextRow = Row;
        NextCol = Col + 1'b1;
        if (Col == LAST_COL) begin
            NextCol = '0;
            NextRow = LastPos ? '0 : Row + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            Row <= '0;
            Col <= '0;
        end else if (Step) begin
            Row <= NextRow;
            Col <= NextCol;
        end
    end

endmodule

// File: rtl/sad_search_ctrl.sv
// Window/frame SAD search sequencer; scans all block positions and keeps the minimum.
// Optional: define SAD_EARLY_EXIT_EN to stop the scan at the first zero SAD.
module sad_search_ctrl
    import sad_ctrl_pkg::*;
#(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN     = 4,
    parameter int SAD_W   = 32,
    parameter int COORD_W = 8,
    parameter int SAD_LAT = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    output logic               LoadReq,
    output logic               LoadSel,
    output logic [COORD_W-1:0] LoadRow,
    output logic [COORD_W-1:0] LoadCol,
    input  logic               LoadAck,
    output logic [1:0]         RegWrite,
    input  logic [SAD_W-1:0]   SadIn,
    output logic [SAD_W-1:0]   BestSad,
    output logic [COORD_W-1:0] BestRow,
    output logic [COORD_W-1:0] BestCol,
    output logic               Busy,
    output logic               Done
);

    localparam int LAT_W = $clog2(SAD_LAT + 1);

    state_t             state;
    logic [SAD_W-1:0]   sad_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic [COORD_W-1:0] row, col, next_row, next_col;
    logic               last_pos;
    logic               pos_clear, pos_step;

    assign pos_clear = (state == IDLE) && Start;
    assign pos_step  = (state == ADVANCE) && !last_pos;

    sad_pos_counter #(
        .FRAME_W(FRAME_W),
        .FRAME_H(FRAME_H),
        .WIN    (WIN),
        .COORD_W(COORD_W)
    ) u_pos (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (pos_clear),
        .Step   (pos_step),
        .Row    (row),
        .Col    (col),
        .NextRow(next_row),
        .NextCol(next_col),
        .LastPos(last_pos)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            LoadReq  <= 1'b0;
            LoadSel  <= LOADSEL_WIN;
            LoadRow  <= '0;
            LoadCol  <= '0;
            RegWrite <= REGWR_NONE;
            BestSad  <= '0;
            BestRow  <= '0;
            BestCol  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            sad_q    <= '0;
            lat_cnt  <= '0;
        end else begin
            RegWrite <= REGWR_NONE;
            Done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= LOAD_WIN;
                        LoadReq <= 1'b1;
                        LoadSel <= LOADSEL_WIN;
                        LoadRow <= '0;
                        LoadCol <= '0;
                        Busy    <= 1'b1;
                        BestSad <= '1;
                        BestRow <= '0;
                        BestCol <= '0;
                    end
                end
                LOAD_WIN: begin
                    if (LoadReq && LoadAck) begin
                        LoadReq  <= 1'b0;
                        RegWrite <= REGWR_WINDOW;
                        state    <= LOAD_FRM;
                    end
                end
                // Entered with LoadReq low after the window write; raise the frame request here.
                LOAD_FRM: begin
                    if (!LoadReq) begin
                        LoadReq <= 1'b1;
                        LoadSel <= LOADSEL_FRM;
                        LoadRow <= row;
                        LoadCol <= col;
                    end else if (LoadAck) begin
                        LoadReq  <= 1'b0;
                        RegWrite <= REGWR_FRAME;
                        lat_cnt  <= LAT_W'(SAD_LAT);
                        state    <= WAIT_SAD;
                    end
                end
                WAIT_SAD: begin
                    if (lat_cnt == '0) begin
                        sad_q <= SadIn;
                        state <= COMPARE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                COMPARE: begin
                    if (sad_q < BestSad) begin
                        BestSad <= sad_q;
                        BestRow <= row;
                        BestCol <= col;
                    end
`ifdef SAD_EARLY_EXIT_EN
                    if (sad_q == '0) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= ADVANCE;
                    end
`else
                    state <= ADVANCE;
`endif
                end
                ADVANCE: begin
                    if (last_pos) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        LoadReq <= 1'b1;
                        LoadSel <= LOADSEL_FRM;
                        LoadRow <= next_row;
                        LoadCol <= next_col;
                        state   <= LOAD_FRM;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
- Sequencer for the SAD window/frame register bank and its SAD datapath.
- Loads the 4x4 search window once, then raster-scans every candidate block position in the frame: requests each block load, writes it into the bank's frame half, waits for the SAD result and tracks the minimum.
- Sits between the top-level control (Start/Done) and the block loader, the register bank and the SAD adder tree.

Parameters:
- FRAME_W, 64, frame width in pixels
- FRAME_H, 64, frame height in pixels
- WIN, 4, window edge; the bank holds WIN*WIN = 16 words per half
- SAD_W, 32, SAD result width
- COORD_W, 8, row/col coordinate width; must satisfy 2^COORD_W > max(FRAME_W, FRAME_H)
- SAD_LAT, 2, cycles from the frame write cycle to a valid SadIn (min 1)

Ports:
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse; begins a search; ignored unless IDLE
- LoadReq  out  1  request a block load from the loader
- LoadSel  out  1  0 = window block, 1 = frame block
- LoadRow  out  COORD_W  frame block top-left row (0 when LoadSel=0)
- LoadCol  out  COORD_W  frame block top-left col (0 when LoadSel=0)
- LoadAck  in  1  loader's 16 WriteData words valid this cycle
- RegWrite  out  2  bank write code: 00 none, 01 window, 11 frame
- SadIn  in  SAD_W  SAD of the current window and frame block
- BestSad  out  SAD_W  minimum SAD found
- BestRow  out  COORD_W  row of BestSad
- BestCol  out  COORD_W  col of BestSad
- Busy  out  1  high from the cycle after Start until Done
- Done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; LoadReq=0, LoadSel=0, LoadRow=0, LoadCol=0, RegWrite=00, BestSad=0, BestRow=0, BestCol=0, Busy=0, Done=0. Reset mid-search aborts immediately with no Done pulse.
- All outputs are registered.
- RegWrite is asserted for exactly one cycle, the cycle after LoadAck is sampled. This keeps it stable across the bank's negedge write.
- State machine:
  - IDLE: on Start, go to LOAD_WIN; BestSad is set to all-ones, BestRow/BestCol to 0, and row/col counters to 0.
  - LOAD_WIN: LoadReq=1, LoadSel=0, held until LoadAck. On LoadAck: LoadReq=0 and RegWrite=01 next cycle; go to LOAD_FRM.
  - LOAD_FRM: LoadReq=1, LoadSel=1, LoadRow/LoadCol = current position, held until LoadAck. On LoadAck: RegWrite=11 next cycle; load the latency counter with SAD_LAT; go to WAIT_SAD.
  - WAIT_SAD: the counter decrements each cycle after the RegWrite cycle. When it reaches 0, sample SadIn and go to COMPARE.
  - COMPARE: if SadIn < BestSad (strictly less), update BestSad/BestRow/BestCol. Ties keep the earlier position in raster order. Go to ADVANCE.
  - ADVANCE: col increments. At col = FRAME_W-WIN, col wraps to 0 and row increments. If the position was the last one (row = FRAME_H-WIN, col = FRAME_W-WIN), go to DONE; otherwise go to LOAD_FRM.
  - DONE: Done=1 for one cycle, Busy drops in the same cycle; go to IDLE.
- Results hold until the next Start.
- LoadAck outside LOAD_WIN/LOAD_FRM is ignored.
- Degenerate frame: FRAME_W=WIN and FRAME_H=WIN gives exactly one position.
- Position count = (FRAME_H-WIN+1)*(FRAME_W-WIN+1). With 1-cycle acks, each position costs 1+1+SAD_LAT+2 cycles.

Optional Feature:
- Macro: SAD_EARLY_EXIT_EN
- Defined: in COMPARE, SadIn == 0 updates the best values and goes straight to DONE, skipping the remaining positions.
- Undefined: every position is always scanned, and a zero SAD is treated like any other minimum.

Decomposition:
- Package sad_ctrl_pkg holds:
  - the state enum (IDLE, LOAD_WIN, LOAD_FRM, WAIT_SAD, COMPARE, ADVANCE, DONE)
  - the RegWrite codes REGWR_NONE=2'b00, REGWR_WINDOW=2'b01, REGWR_FRAME=2'b11
  - LOADSEL_WIN/LOADSEL_FRM constants
- One sub-module, sad_pos_counter: raster row/col counter with clear, step, wrap and a last_pos flag.

Test Plan (FRAME_W=6, FRAME_H=5, WIN=4, SAD_LAT=2 unless noted; 6 positions):
- Start, ack every request after 1 cycle, SadIn = 50,40,30,35,60,45 -> RegWrite pattern 01 then 11 x6; BestSad=30, BestRow=0, BestCol=2; one Done pulse; 6 frame LoadReqs in raster order (0,0) through (1,2).
- SadIn = 20 at (0,1) and at (1,1), others 99 -> tie keeps BestRow=0, BestCol=1.
- LoadAck withheld 5 cycles on the window load -> LoadReq held for 5 cycles; RegWrite=01 exactly one cycle after the ack; no RegWrite before it.
- Reset asserted while in WAIT_SAD at position (1,0) -> next cycle all outputs at reset values and no Done; a following Start reruns cleanly from (0,0).
- Start pulsed again while Busy -> ignored; the position sequence and the results are unchanged.
- SAD_EARLY_EXIT_EN defined, SadIn=0 at (0,1) -> Done after COMPARE at (0,1), BestSad=0, no LoadReq for (0,2); with the macro undefined, all 6 positions are scanned.
